// File: rtl/lp_filter_pkg.sv
// lp_filter_pkg
//   Types shared by the time-shared low-pass filter scheduler and its helpers.
//   fsm_state_t : scheduler sequence IDLE -> GRANT -> READ -> CALC -> WRITE.
package lp_filter_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    READ  = 3'd2,
    CALC  = 3'd3,
    WRITE = 3'd4
  } fsm_state_t;

endpackage

// File: rtl/lp_filter_step.sv
// lp_filter_step
//   Combinational single-pole low-pass update for one channel:
//     s          = in scaled up to the state width
//     d          = s - state                (signed, one guard bit)
//     state_next = state + floor(d / 2^k)
//   The first update after reset preloads the state with s.
// Ports
//   i_in          : unsigned input sample (IN_DATA_BITS)
//   i_state       : current filter state (OUT_DATA_BITS)
//   i_shift       : smoothing shift k (SHIFT_BITS)
//   i_init_done   : 1 once this channel has been preloaded
//   o_state_next  : updated filter state (OUT_DATA_BITS)
module lp_filter_step
  import lp_filter_pkg::*;
#(
  parameter int IN_DATA_BITS  = 28,
  parameter int OUT_DATA_BITS = 30,
  parameter int SHIFT_BITS    = 5
) (
  input  logic [IN_DATA_BITS-1:0]  i_in,
  input  logic [OUT_DATA_BITS-1:0] i_state,
  input  logic [SHIFT_BITS-1:0]    i_shift,
  input  logic                     i_init_done,
  output logic [OUT_DATA_BITS-1:0] o_state_next
);

  logic        [OUT_DATA_BITS-1:0] w_s;
  logic signed [OUT_DATA_BITS:0]   w_d;
  logic signed [OUT_DATA_BITS:0]   w_sum;

  // Floor division by 2^k; the step never exceeds |d|, so the sum always
  // lands between state and s and cannot wrap.
  function automatic logic signed [OUT_DATA_BITS:0] floor_shift(
    input logic signed [OUT_DATA_BITS:0] d,
    input logic        [SHIFT_BITS-1:0]  k
  );
    return d >>> k;
  endfunction

  assign w_s   = OUT_DATA_BITS'(i_in) << (OUT_DATA_BITS - IN_DATA_BITS);
  assign w_d   = $signed({1'b0, w_s}) - $signed({1'b0, i_state});
  assign w_sum = $signed({1'b0, i_state}) + floor_shift(w_d, i_shift);

  assign o_state_next = i_init_done ? w_sum[OUT_DATA_BITS-1:0] : w_s;

endmodule

// File: rtl/lp_filter_scheduler.sv
// lp_filter_scheduler
//   Shares one lp_filter_step datapath among NUM_CHANNELS channels. Incoming
//   samples park in per-channel pending registers; a round-robin FSM picks
//   one pending channel at a time and runs GRANT/READ/CALC/WRITE on it.
// Ports
//   CLK, RESET   : clock, synchronous active-high reset
//   CE           : clock enable, freezes all state when low
//   IN_VALUE     : packed per-channel samples (NUM_CHANNELS x IN_DATA_BITS)
//   IN_VALID     : per-channel sample strobes
//   SHIFT_CFG    : packed per-channel shift k, sampled in READ
//   OUT_VALUE    : packed per-channel filtered values (registered)
//   OUT_VALID    : one-cycle update strobe
//   OUT_CHANNEL  : channel index of the update being reported
//   OVERRUN      : sticky per-channel flag, pending sample was overwritten
module lp_filter_scheduler
  import lp_filter_pkg::*;
#(
  parameter int NUM_CHANNELS  = 2,
  parameter int IN_DATA_BITS  = 28,
  parameter int OUT_DATA_BITS = 30,
  parameter int SHIFT_BITS    = 5
) (
  input  logic                                  CLK,
  input  logic                                  RESET,
  input  logic                                  CE,
  input  logic [NUM_CHANNELS*IN_DATA_BITS-1:0]  IN_VALUE,
  input  logic [NUM_CHANNELS-1:0]               IN_VALID,
  input  logic [NUM_CHANNELS*SHIFT_BITS-1:0]    SHIFT_CFG,
  output logic [NUM_CHANNELS*OUT_DATA_BITS-1:0] OUT_VALUE,
  output logic                                  OUT_VALID,
  output logic [$clog2(NUM_CHANNELS)-1:0]       OUT_CHANNEL,
  output logic [NUM_CHANNELS-1:0]               OVERRUN
);

  localparam int CH_W = $clog2(NUM_CHANNELS);

  fsm_state_t                r_state;
  logic [IN_DATA_BITS-1:0]   r_pending   [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]   r_pend_flag;
  logic [NUM_CHANNELS-1:0]   r_overrun;
  logic [NUM_CHANNELS-1:0]   r_init_flag;
  logic [OUT_DATA_BITS-1:0]  r_bank      [NUM_CHANNELS];
  logic [OUT_DATA_BITS-1:0]  r_out_value [NUM_CHANNELS];
  logic [CH_W-1:0]           r_last_granted;
  logic [CH_W-1:0]           r_cur_ch;
  logic [IN_DATA_BITS-1:0]   r_work_in;
  logic [OUT_DATA_BITS-1:0]  r_work_state;
  logic [SHIFT_BITS-1:0]     r_work_shift;
  logic                      r_work_init;
  logic [OUT_DATA_BITS-1:0]  r_state_next;
  logic                      r_out_valid;
  logic [CH_W-1:0]           r_out_channel;

  logic [CH_W-1:0]           w_grant_ch;
  logic                      w_found;
  logic [NUM_CHANNELS-1:0]   w_grant_vec;
  logic [OUT_DATA_BITS-1:0]  w_state_next;

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    w_grant_ch = '0;
    w_found    = 1'b0;
    for (int j = 1; j <= NUM_CHANNELS; j++) begin
      int c;
      c = (int'(r_last_granted) + j) % NUM_CHANNELS;
      if (!w_found && r_pend_flag[c]) begin
        w_found    = 1'b1;
        w_grant_ch = CH_W'(c);
      end
    end
  end

  always_comb begin
    w_grant_vec = '0;
    if (r_state == GRANT && w_found) w_grant_vec[w_grant_ch] = 1'b1;
  end

  lp_filter_step #(
    .IN_DATA_BITS  (IN_DATA_BITS),
    .OUT_DATA_BITS (OUT_DATA_BITS),
    .SHIFT_BITS    (SHIFT_BITS)
  ) u_step (
    .i_in         (r_work_in),
    .i_state      (r_work_state),
    .i_shift      (r_work_shift),
    .i_init_done  (r_work_init),
    .o_state_next (w_state_next)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state        <= IDLE;
      r_pend_flag    <= '0;
      r_overrun      <= '0;
      r_init_flag    <= '0;
      r_last_granted <= CH_W'(NUM_CHANNELS - 1);
      r_cur_ch       <= '0;
      r_work_in      <= '0;
      r_work_state   <= '0;
      r_work_shift   <= '0;
      r_work_init    <= 1'b0;
      r_state_next   <= '0;
      r_out_valid    <= 1'b0;
      r_out_channel  <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        r_pending[i]   <= '0;
        r_bank[i]      <= '0;
        r_out_value[i] <= '0;
      end
    end else if (CE) begin
      r_out_valid <= 1'b0;

      // Input capture. A strobe on the channel being granted this cycle
      // re-arms it with the new sample; the grant takes the old one.
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (IN_VALID[i]) begin
          r_pending[i]   <= IN_VALUE[i*IN_DATA_BITS +: IN_DATA_BITS];
          r_pend_flag[i] <= 1'b1;
          if (r_pend_flag[i] && !w_grant_vec[i]) r_overrun[i] <= 1'b1;
        end else if (w_grant_vec[i]) begin
          r_pend_flag[i] <= 1'b0;
        end
      end

      case (r_state)
        IDLE: begin
          if (|r_pend_flag) r_state <= GRANT;
        end
        // GRANT: pick channel, move its sample into the working register
        GRANT: begin
          r_cur_ch       <= w_grant_ch;
          r_last_granted <= w_grant_ch;
          r_work_in      <= r_pending[w_grant_ch];
          r_state        <= READ;
        end
        // READ: fetch state, init flag and shift for the channel
        READ: begin
          r_work_state <= r_bank[r_cur_ch];
          r_work_init  <= r_init_flag[r_cur_ch];
          r_work_shift <= SHIFT_CFG[r_cur_ch*SHIFT_BITS +: SHIFT_BITS];
          r_state      <= CALC;
        end
        // CALC: register the datapath result
        CALC: begin
          r_state_next <= w_state_next;
          r_state      <= WRITE;
        end
        // WRITE: commit to state bank and output, pulse the strobe
        WRITE: begin
          r_bank[r_cur_ch]      <= r_state_next;
          r_out_value[r_cur_ch] <= r_state_next;
          r_init_flag[r_cur_ch] <= 1'b1;
          r_out_valid           <= 1'b1;
          r_out_channel         <= r_cur_ch;
          r_state               <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_out
    assign OUT_VALUE[g*OUT_DATA_BITS +: OUT_DATA_BITS] = r_out_value[g];
  end

  // The strobe register holds while CE is low; gating keeps it from being
  // seen until the enable returns, so one update is reported exactly once.
  assign OUT_VALID   = r_out_valid & CE;
  assign OUT_CHANNEL = r_out_channel;
  assign OVERRUN     = r_overrun;

endmodule

// File: tb/tb_lp_filter_scheduler.sv
module tb_lp_filter_scheduler;

  localparam int NCH = 2;
  localparam int IW  = 28;
  localparam int OW  = 30;
  localparam int SW  = 5;
  localparam int K   = 5;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic              CE = 1'b1;
  logic [NCH*IW-1:0] IN_VALUE = '0;
  logic [NCH-1:0]    IN_VALID = '0;
  logic [NCH*SW-1:0] SHIFT_CFG = {5'd5, 5'd5};
  logic [NCH*OW-1:0] OUT_VALUE;
  logic              OUT_VALID;
  logic [0:0]        OUT_CHANNEL;
  logic [NCH-1:0]    OVERRUN;

  lp_filter_scheduler #(
    .NUM_CHANNELS (NCH),
    .IN_DATA_BITS (IW),
    .OUT_DATA_BITS(OW),
    .SHIFT_BITS   (SW)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .CE         (CE),
    .IN_VALUE   (IN_VALUE),
    .IN_VALID   (IN_VALID),
    .SHIFT_CFG  (SHIFT_CFG),
    .OUT_VALUE  (OUT_VALUE),
    .OUT_VALID  (OUT_VALID),
    .OUT_CHANNEL(OUT_CHANNEL),
    .OVERRUN    (OVERRUN)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int     ch;
    longint val;
    int     cyc;
  } exp_t;

  exp_t   sb_q[$];
  int     errors = 0;
  int     checks = 0;
  longint mon_min0 = 64'h7fffffff;
  longint mon_last0 = 0;

  longint m_state[NCH];
  bit     m_init[NCH];

  // Reference filter: floor division written out explicitly.
  function automatic longint model_update(int ch, longint in_v);
    longint s, d, p, q, r;
    s = in_v * 4;
    if (!m_init[ch]) r = s;
    else begin
      d = s - m_state[ch];
      p = longint'(1) << K;
      if (d >= 0) q = d / p;
      else        q = -((-d + p - 1) / p);
      r = m_state[ch] + q;
    end
    m_state[ch] = r;
    m_init[ch]  = 1'b1;
    return r;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic set_in(input int ch, input longint v);
    logic [IW-1:0] tmp;
    tmp = v[IW-1:0];
    IN_VALUE[ch*IW +: IW] = tmp;
    IN_VALID[ch] = 1'b1;
  endtask

  task automatic push(input int ch, input longint v, input int c);
    exp_t e;
    e.ch = ch; e.val = v; e.cyc = c;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d updates outstanding, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic do_reset();
    IN_VALID = '0;
    CE = 1'b1;
    RESET = 1'b1;
    tick(); tick();
    RESET = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      m_state[i] = 0;
      m_init[i]  = 1'b0;
    end
  endtask

  initial begin
    fork
      // Monitor: pops the scoreboard whenever the DUT reports an update.
      begin
        forever begin
          @(posedge CLK);
          #1;
          if (OUT_VALID) begin
            if (sb_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_update: ch=%0d value=%0d, required no update",
                       OUT_CHANNEL, OUT_VALUE[OUT_CHANNEL*OW +: OW]);
            end else begin
              exp_t e;
              longint v;
              e = sb_q.pop_front();
              v = longint'(OUT_VALUE[e.ch*OW +: OW]);
              check("out_channel", longint'(OUT_CHANNEL), e.ch);
              check("out_value", v, e.val);
              if (e.cyc >= 0) check("out_latency_cycle", cyc, e.cyc);
              if (e.ch == 0) begin
                mon_last0 = v;
                if (v < mon_min0) mon_min0 = v;
              end
            end
          end
        end
      end
      // Driver
      begin
        int n;
        longint hold;
        do_reset();
        tick();
        check("reset_out_valid", longint'(OUT_VALID), 0);
        check("reset_out_value", longint'(OUT_VALUE), 0);
        check("reset_overrun", longint'(OVERRUN), 0);
        check("reset_out_channel", longint'(OUT_CHANNEL), 0);

        // Preload, then first filtered step (hand-computed)
        n = cyc + 1;
        set_in(0, 109377165);
        void'(model_update(0, 109377165));
        push(0, 437508660, n + 5);
        tick(); IN_VALID = '0;
        drain();

        n = cyc + 1;
        set_in(0, 54688582);
        void'(model_update(0, 54688582));
        push(0, 430672587, n + 5);
        tick(); IN_VALID = '0;
        drain();

        // Convergence toward 218754328
        mon_min0 = 64'h7fffffff;
        for (int i = 0; i < 2000; i++) begin
          n = cyc + 1;
          set_in(0, 54688582);
          push(0, model_update(0, 54688582), n + 5);
          tick(); IN_VALID = '0;
          drain();
        end
        check("no_undershoot", longint'(mon_min0 >= 218754328), 1);
        check("converged_within_31",
              longint'((mon_last0 - 218754328) <= 31 && (mon_last0 - 218754328) >= 0), 1);

        // Simultaneous strobes: ch0 then ch1, 5 cycles apart
        do_reset();
        tick();
        n = cyc + 1;
        set_in(0, 1000);
        set_in(1, 2000);
        push(0, model_update(0, 1000), n + 5);
        push(1, model_update(1, 2000), n + 10);
        tick(); IN_VALID = '0;
        drain();
        check("simul_overrun", longint'(OVERRUN), 0);

        // Overrun on ch1 while ch0 occupies the datapath
        do_reset();
        tick();
        n = cyc + 1;
        set_in(0, 3000);
        push(0, model_update(0, 3000), n + 5);
        tick(); IN_VALID = '0;
        tick();
        set_in(1, 11111); tick();
        set_in(1, 22222); tick();
        set_in(1, 33333);
        push(1, model_update(1, 33333), n + 10);
        tick(); IN_VALID = '0;
        drain();
        repeat (10) tick();
        check("overrun_flag", longint'(OVERRUN), 2);

        // CE low for 10 cycles mid-CALC
        do_reset();
        tick();
        set_in(0, 4000);
        push(0, model_update(0, 4000), -1);
        tick(); IN_VALID = '0;
        drain();
        n = cyc + 1;
        set_in(0, 8000);
        push(0, model_update(0, 8000), n + 15);
        tick(); IN_VALID = '0;
        tick(); tick(); tick();
        CE = 1'b0;
        hold = longint'(OUT_VALUE);
        set_in(1, 777);
        tick(); IN_VALID = '0;
        repeat (9) tick();
        check("ce_hold_value", longint'(OUT_VALUE), hold);
        check("ce_hold_valid", longint'(OUT_VALID), 0);
        CE = 1'b1;
        drain();
        repeat (10) tick();

        // Reset during CALC aborts; next update preloads
        set_in(0, 5000);
        tick(); IN_VALID = '0;
        tick(); tick(); tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        m_state[0] = 0; m_init[0] = 1'b0;
        m_state[1] = 0; m_init[1] = 1'b0;
        repeat (10) tick();
        check("abort_out_valid", longint'(OUT_VALID), 0);
        n = cyc + 1;
        set_in(0, 123456);
        void'(model_update(0, 123456));
        push(0, 493824, n + 5);
        tick(); IN_VALID = '0;
        drain();
        repeat (5) tick();
      end
      // Watchdog
      begin
        repeat (60000) @(posedge CLK);
        checks++;
        errors++;
        $display("FAIL watchdog: cycle %0d reached, required completion earlier", cyc);
      end
    join_any
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
